// File: rtl/calculadora_multimodo.sv
// Command-driven decimal calculator: key entry, add/sub/shift-add mul, streamed BCD result.
// Optional restoring divider is built only when CALC_DIV_EN is defined.
module calculadora_multimodo #(
   parameter int DIGITS = 8,
   parameter int WIDTH  = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] i_cmd,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   output logic [1:0] o_status,
   output logic [3:0] o_pos,
   output logic [3:0] o_dig,
   output logic       o_dig_valid,
   output logic       o_neg
);
   localparam int CW  = 5;
   localparam int CYW = $clog2(WIDTH + DIGITS + 1) + 1;
   localparam int XW  = WIDTH + 4;
   localparam int PW  = 2 * WIDTH;

   localparam logic [3:0] OP_ADD = 4'hA;
   localparam logic [3:0] OP_SUB = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;
   localparam logic [3:0] OP_DIV = 4'hD;
   localparam logic [3:0] K_EQ   = 4'hE;
   localparam logic [3:0] K_BS   = 4'hF;

   function automatic logic [XW-1:0] max_value();
      logic [XW-1:0] v;
      v = XW'(1);
      for (int k = 0; k < DIGITS; k++) v = (v << 3) + (v << 1);
      return v - XW'(1);
   endfunction

   localparam logic [XW-1:0] MAX = max_value();

   function automatic logic [3:0] mod10(input logic [WIDTH-1:0] v);
      return 4'(v % WIDTH'(10));
   endfunction

   function automatic logic [WIDTH-1:0] div10(input logic [WIDTH-1:0] v);
      return v / WIDTH'(10);
   endfunction

   typedef enum logic [2:0] {S_PRONTA, S_ERRO, S_CALC, S_CHECK, S_SHOW} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_reg1, r_reg2, r_show;
   logic [CW-1:0]    r_cnt1, r_cnt2;
   logic [3:0]       r_op, r_pos, r_dig;
   logic             r_set_op, r_after, r_neg, r_dig_valid;
   logic [CYW-1:0]   r_cyc;
   logic [PW-1:0]    r_acc, r_mcand;

   logic [WIDTH-1:0] w_cur;
   logic [CW-1:0]    w_cnt, w_newcnt;
   logic [XW-1:0]    w_new;
   logic             w_accept;

   // The operand being edited; a finished result counts as an empty operand.
   always_comb begin
      w_cur = '0;
      w_cnt = '0;
      if (!r_after) begin
         w_cur = r_set_op ? r_reg2 : r_reg1;
         w_cnt = r_set_op ? r_cnt2 : r_cnt1;
      end
      w_new    = ({4'd0, w_cur} << 3) + ({4'd0, w_cur} << 1) + XW'(i_cmd);
      w_newcnt = w_cnt + CW'(1);
   end

`ifdef CALC_DIV_EN
   logic [WIDTH:0] r_rem, w_rem_sh, w_trial;
   assign w_rem_sh = {r_rem[WIDTH-1:0], r_reg1[WIDTH-1]};
   assign w_trial  = w_rem_sh - {1'b0, r_reg2};
`endif

   assign o_cmd_ready = (r_state == S_PRONTA) || (r_state == S_ERRO);
   assign o_status    = (r_state == S_ERRO) ? 2'b00 : (r_state == S_PRONTA) ? 2'b01 : 2'b10;
   assign w_accept    = i_cmd_valid && o_cmd_ready;
   assign o_pos       = r_pos;
   assign o_dig       = r_dig;
   assign o_dig_valid = r_dig_valid;
   assign o_neg       = r_neg;

   always_ff @(posedge clock) begin
      r_dig_valid <= 1'b0;
      if (reset) begin
         r_state  <= S_PRONTA;
         r_reg1   <= '0;
         r_reg2   <= '0;
         r_cnt1   <= '0;
         r_cnt2   <= '0;
         r_set_op <= 1'b0;
         r_op     <= OP_ADD;
         r_after  <= 1'b0;
         r_neg    <= 1'b0;
         r_pos    <= '0;
         r_dig    <= '0;
         r_cyc    <= '0;
      end else begin
         case (r_state)
            S_PRONTA: if (w_accept) begin
               if (i_cmd <= 4'd9) begin
                  if (w_new > MAX || w_newcnt > CW'(DIGITS)) begin
                     r_state <= S_ERRO;
                  end else begin
                     if (r_after) begin
                        r_reg2  <= '0;
                        r_cnt2  <= '0;
                        r_neg   <= 1'b0;
                        r_after <= 1'b0;
                     end
                     if (r_set_op && !r_after) begin
                        r_reg2 <= w_new[WIDTH-1:0];
                        r_cnt2 <= w_newcnt;
                     end else begin
                        r_reg1 <= w_new[WIDTH-1:0];
                        r_cnt1 <= w_newcnt;
                     end
                     r_dig       <= i_cmd;
                     r_pos       <= 4'(w_newcnt - CW'(1));
                     r_dig_valid <= 1'b1;
                  end
               end else if (i_cmd == K_EQ) begin
                  r_cyc   <= '0;
                  r_acc   <= '0;
                  r_mcand <= PW'(r_reg1);
`ifdef CALC_DIV_EN
                  r_rem   <= '0;
`endif
                  if (!r_set_op) begin
                     r_acc   <= PW'(r_reg1);
                     r_neg   <= 1'b0;
                     r_state <= S_CHECK;
`ifdef CALC_DIV_EN
                  end else if (r_op == OP_DIV && r_reg2 == '0) begin
                     r_state <= S_ERRO;
`endif
                  end else begin
                     r_state <= S_CALC;
                  end
               end else if (i_cmd == K_BS) begin
                  if (r_set_op && r_cnt2 == '0) begin
                     r_set_op <= 1'b0;
                  end else if (w_cnt != '0) begin
                     if (r_set_op) begin
                        r_reg2 <= div10(r_reg2);
                        r_cnt2 <= r_cnt2 - CW'(1);
                     end else begin
                        r_reg1 <= div10(r_reg1);
                        r_cnt1 <= r_cnt1 - CW'(1);
                     end
                     r_pos <= (w_cnt > CW'(1)) ? 4'(w_cnt - CW'(2)) : 4'd0;
                  end
`ifndef CALC_DIV_EN
               end else if (i_cmd == OP_DIV) begin
                  r_state <= S_ERRO;
`endif
               end else if (r_cnt2 == '0) begin
                  r_op     <= i_cmd;
                  r_set_op <= 1'b1;
                  r_neg    <= 1'b0;
                  r_after  <= 1'b0;
               end
            end
            S_ERRO: if (w_accept && i_cmd == K_BS) begin
               r_reg1   <= '0;
               r_reg2   <= '0;
               r_cnt1   <= '0;
               r_cnt2   <= '0;
               r_set_op <= 1'b0;
               r_op     <= OP_ADD;
               r_after  <= 1'b0;
               r_neg    <= 1'b0;
               r_pos    <= '0;
               r_dig    <= '0;
               r_state  <= S_PRONTA;
            end
            // CALC: add/sub finish in one cycle, mul/div iterate one bit per cycle
            S_CALC: begin
               r_cyc <= r_cyc + CYW'(1);
               case (r_op)
                  OP_ADD: begin
                     r_acc   <= PW'(r_reg1) + PW'(r_reg2);
                     r_neg   <= 1'b0;
                     r_state <= S_CHECK;
                  end
                  OP_SUB: begin
                     r_acc   <= (r_reg1 < r_reg2) ? PW'(r_reg2 - r_reg1) : PW'(r_reg1 - r_reg2);
                     r_neg   <= (r_reg1 < r_reg2);
                     r_state <= S_CHECK;
                  end
                  OP_MUL: begin
                     if (r_reg2[0]) r_acc <= r_acc + r_mcand;
                     r_mcand <= r_mcand << 1;
                     r_reg2  <= r_reg2 >> 1;
                     r_neg   <= 1'b0;
                     if (r_cyc == CYW'(WIDTH - 1)) r_state <= S_CHECK;
                  end
`ifdef CALC_DIV_EN
                  OP_DIV: begin
                     r_rem  <= w_trial[WIDTH] ? w_rem_sh : w_trial;
                     r_reg1 <= {r_reg1[WIDTH-2:0], ~w_trial[WIDTH]};
                     r_neg  <= 1'b0;
                     if (r_cyc == CYW'(WIDTH - 1)) begin
                        r_acc   <= PW'({r_reg1[WIDTH-2:0], ~w_trial[WIDTH]});
                        r_state <= S_CHECK;
                     end
                  end
`endif
                  default: r_state <= S_ERRO;
               endcase
            end
            // CHECK: range test, then emit digit 0 and chain the result into reg1
            S_CHECK: begin
               if (r_acc > PW'(MAX)) begin
                  r_state <= S_ERRO;
               end else begin
                  r_dig       <= mod10(r_acc[WIDTH-1:0]);
                  r_pos       <= '0;
                  r_dig_valid <= 1'b1;
                  r_show      <= div10(r_acc[WIDTH-1:0]);
                  r_cyc       <= CYW'(1);
                  r_reg1      <= r_acc[WIDTH-1:0];
                  r_reg2      <= '0;
                  r_cnt1      <= '0;
                  r_cnt2      <= '0;
                  r_set_op    <= 1'b0;
                  r_after     <= 1'b1;
                  r_state     <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (r_cyc == CYW'(DIGITS)) begin
                  r_state <= S_PRONTA;
               end else begin
                  r_dig       <= mod10(r_show);
                  r_pos       <= 4'(r_cyc);
                  r_dig_valid <= 1'b1;
                  r_show      <= div10(r_show);
                  r_cyc       <= r_cyc + CYW'(1);
               end
            end
            default: r_state <= S_PRONTA;
         endcase
      end
   end
endmodule

// File: tb/tb_calculadora_multimodo.sv
// Bench for calculadora_multimodo: directed key sequences plus random keys against a decimal model.
module tb_calculadora_multimodo;
   localparam int DIGITS = 8;
   localparam int WIDTH  = 32;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] i_cmd = 4'd0;
   logic       i_cmd_valid = 1'b0;
   logic       o_cmd_ready, o_dig_valid, o_neg;
   logic [1:0] o_status;
   logic [3:0] o_pos, o_dig;

   calculadora_multimodo #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
      .o_cmd_ready(o_cmd_ready), .o_status(o_status), .o_pos(o_pos), .o_dig(o_dig),
      .o_dig_valid(o_dig_valid), .o_neg(o_neg)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   longint m_a, m_b;
   int     m_ca, m_cb;
   bit     m_setop, m_after, m_neg, m_err;
   logic [3:0] m_op;

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int k = 0; k < n; k++) p = p * 10;
      return p;
   endfunction

   localparam longint MAXV = 64'd99999999;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_a = 0; m_b = 0; m_ca = 0; m_cb = 0;
      m_setop = 0; m_after = 0; m_neg = 0; m_err = 0; m_op = 4'hA;
   endtask

   task automatic key(input logic [3:0] c);
      longint v, r;
      int cnt, calc, busy;
      bit div0;
      int got_d[$];
      int got_p[$];
      @(negedge clock);
      chk("ready", 64'(o_cmd_ready), 1);
      i_cmd = c;
      i_cmd_valid = 1'b1;
      @(posedge clock);
      #1;
      i_cmd_valid = 1'b0;
      if (m_err) begin
         if (c == 4'hF) begin
            model_clear();
            chk("clr_status", 64'(o_status), 1);
            chk("clr_posdig", 64'({o_pos, o_dig}), 0);
            chk("clr_neg", 64'(o_neg), 0);
         end else begin
            chk("err_hold", 64'(o_status), 0);
         end
      end else if (c <= 4'd9) begin
         if (m_after) begin
            m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_neg = 0; m_after = 0;
         end
         v = m_setop ? m_b : m_a;
         cnt = m_setop ? m_cb : m_ca;
         v = v * 10 + longint'(c);
         cnt++;
         if (v > MAXV || cnt > DIGITS) begin
            m_err = 1;
            chk("ovf_status", 64'(o_status), 0);
         end else begin
            if (m_setop) begin m_b = v; m_cb = cnt; end
            else begin m_a = v; m_ca = cnt; end
            chk("echo_vld", 64'(o_dig_valid), 1);
            chk("echo_dig", 64'(o_dig), 64'(c));
            chk("echo_pos", 64'(o_pos), 64'(cnt - 1));
         end
      end else if (c != 4'hE && c != 4'hF) begin
`ifndef CALC_DIV_EN
         if (c == 4'hD) m_err = 1; else
`endif
         if (m_cb == 0) begin
            m_op = c; m_setop = 1; m_neg = 0; m_after = 0;
         end
         chk("op_status", 64'(o_status), m_err ? 0 : 1);
         chk("op_neg", 64'(o_neg), 64'(m_neg));
      end else if (c == 4'hF) begin
         if (m_setop) begin
            if (m_cb > 0) begin m_b = m_b / 10; m_cb--; end
            else m_setop = 0;
         end else if (m_ca > 0) begin
            m_a = m_a / 10; m_ca--;
         end
         chk("bs_status", 64'(o_status), 1);
         chk("bs_vld", 64'(o_dig_valid), 0);
      end else begin
         div0 = 0; calc = 0; r = 0;
         if (!m_setop) begin
            r = m_a; m_neg = 0;
         end else begin
            case (m_op)
               4'hA: begin r = m_a + m_b; calc = 1; m_neg = 0; end
               4'hB: begin
                  calc = 1;
                  if (m_a < m_b) begin r = m_b - m_a; m_neg = 1; end
                  else begin r = m_a - m_b; m_neg = 0; end
               end
               4'hC: begin r = m_a * m_b; calc = WIDTH; m_neg = 0; end
               default: begin
                  if (m_b == 0) div0 = 1; else r = m_a / m_b;
                  calc = WIDTH; m_neg = 0;
               end
            endcase
         end
         busy = 0;
         for (int k = 0; k < 200; k++) begin
            if (o_status != 2'b10) break;
            busy++;
            if (o_dig_valid) begin
               got_d.push_back(int'(o_dig));
               got_p.push_back(int'(o_pos));
            end
            @(negedge clock);
            i_cmd_valid = 1'($urandom_range(0, 1));
            i_cmd = 4'($urandom_range(0, 15));
            @(posedge clock);
            #1;
         end
         i_cmd_valid = 1'b0;
         if (div0) begin
            m_err = 1;
            chk("div0_busy", 64'(busy), 0);
            chk("div0_status", 64'(o_status), 0);
         end else if (r > MAXV) begin
            m_err = 1;
            chk("res_ovf_busy", 64'(busy), 64'(calc + 1));
            chk("res_ovf_ndig", 64'(got_d.size()), 0);
            chk("res_ovf_status", 64'(o_status), 0);
         end else begin
            chk("busy", 64'(busy), 64'(calc + 1 + DIGITS));
            chk("ndig", 64'(got_d.size()), 64'(DIGITS));
            for (int i = 0; i < got_d.size() && i < DIGITS; i++) begin
               chk("res_dig", 64'(got_d[i]), 64'((r / pow10(i)) % 10));
               chk("res_pos", 64'(got_p[i]), 64'(i));
            end
            chk("res_neg", 64'(o_neg), 64'(m_neg));
            chk("res_status", 64'(o_status), 1);
            m_a = r; m_b = 0; m_ca = 0; m_cb = 0; m_setop = 0; m_after = 1;
         end
      end
   endtask

   task automatic reset_mid_mul();
      int seen;
      key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'hC);
      key(4'd5); key(4'd6); key(4'd7); key(4'd8);
      @(negedge clock);
      i_cmd = 4'hE; i_cmd_valid = 1'b1;
      @(posedge clock);
      #1;
      i_cmd_valid = 1'b0;
      chk("mul_busy", 64'(o_status), 2);
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rst_status", 64'(o_status), 1);
      chk("rst_ready", 64'(o_cmd_ready), 1);
      chk("rst_vld", 64'(o_dig_valid), 0);
      chk("rst_posdig", 64'({o_pos, o_dig}), 0);
      chk("rst_neg", 64'(o_neg), 0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (50) begin
         @(posedge clock);
         #1;
         if (o_dig_valid) seen++;
      end
      chk("rst_no_digits", 64'(seen), 0);
      model_clear();
   endtask

   initial begin
      int r;
      model_clear();
      repeat (2) @(posedge clock);
      #1;
      chk("init_status", 64'(o_status), 1);
      chk("init_ready", 64'(o_cmd_ready), 1);
      chk("init_posdig", 64'({o_pos, o_dig}), 0);
      chk("init_vld", 64'(o_dig_valid), 0);
      chk("init_neg", 64'(o_neg), 0);
      @(negedge clock);
      reset = 1'b0;

      key(4'd1); key(4'd2); key(4'hA); key(4'd3); key(4'd4); key(4'hE);
      key(4'd5); key(4'hB); key(4'd9); key(4'hE);
      key(4'hA); key(4'd1); key(4'hE);
      key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'hC);
      key(4'd5); key(4'd6); key(4'd7); key(4'd8); key(4'hE);
      for (int i = 0; i < 8; i++) key(4'd9);
      key(4'hC); key(4'd2); key(4'hE);
      key(4'd7); key(4'hF); key(4'd3); key(4'hE);
      for (int i = 0; i < 9; i++) key(4'd1);
      key(4'hF);
      key(4'd5); key(4'hD);
`ifdef CALC_DIV_EN
      key(4'd7); key(4'hE);
      key(4'd1); key(4'd0); key(4'd0); key(4'hD); key(4'd7); key(4'hE);
      key(4'd5); key(4'hD); key(4'd0); key(4'hE);
`endif
      key(4'hF);
      key(4'd1); key(4'd2); key(4'd3); key(4'hF); key(4'hA); key(4'd4); key(4'hE);
      key(4'd8); key(4'hB); key(4'hC); key(4'hF); key(4'hF); key(4'hE);
      reset_mid_mul();
      key(4'd2); key(4'hA); key(4'd2); key(4'hE);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      key(4'($urandom_range(0, 9)));
         else if (r < 72) key(4'($urandom_range(10, 13)));
         else if (r < 84) key(4'hF);
         else             key(4'hE);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
